mem_access_stage: RTL and testbench

MEM-stage controller between the EX/MEM pipeline register and the MEM/WB register. It takes the registered EX/MEM bundle (ALU result, store data, destination register, control bits) and runs loads and stores over a variable-latency req/ack data-memory port. While an access is outstanding it stalls the upstream pipeline. Its registered outputs are the write-back bundle.

---
 rtl/mem_access_stage_if.sv | 28 ++
 rtl/mem_access_stage.sv | 157 +++++++++++++++
 tb/tb_mem_access_stage.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge port used by the MEM-stage controller.
// master = pipeline stage issuing requests, slave = memory responder.
interface mem_access_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  modport master (
    output dm_req,
    output dm_we,
    output dm_addr,
    output dm_wdata,
    input  dm_rdata,
    input  dm_ack
  );

  modport slave (
    input  dm_req,
    input  dm_we,
    input  dm_addr,
    input  dm_wdata,
    output dm_rdata,
    output dm_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage controller: runs loads/stores over a variable-latency req/ack port and stalls upstream.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned memory ops are dropped with an align_err pulse.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         ALURes,
  input  logic [31:0]         grf_out_B,
  input  logic [31:0]         ext,
  input  logic [4:0]          reg_write_no,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic                RegWrite,
  input  logic [1:0]          DatatoReg,
  output logic                stall,
  mem_access_stage_if.master  dm,
  output logic [31:0]         wb_ALURes,
  output logic [31:0]         wb_mem_data,
  output logic [31:0]         wb_ext,
  output logic [4:0]          wb_reg_write_no,
  output logic                wb_RegWrite,
  output logic [1:0]          wb_DatatoReg,
  output logic                bus_err,
  output logic                align_err
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 32'd1);

  state_t     state_r;
  logic [7:0] cnt_r;
  logic       mem_op_s;
  logic       misalign_s;

  assign mem_op_s = MemRead | MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_s = (ALURes[1:0] != 2'b00);
`else
  assign misalign_s = 1'b0;
`endif

  // Upstream hold: raised on detect and while waiting, dropped on ack or on the abort cycle.
  always_comb begin
    stall = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_op_s && !misalign_s) begin
          stall = 1'b1;
        end else begin
          stall = 1'b0;
        end
      end
      ACCESS: begin
        if (dm.dm_ack) begin
          stall = 1'b0;
        end else if (cnt_r == CNT_LAST) begin
          stall = 1'b0;
        end else begin
          stall = 1'b1;
        end
      end
      default: stall = 1'b0;
    endcase
  end

  // Access FSM with registered memory-port, write-back and error outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r         <= IDLE;
      cnt_r           <= 8'd0;
      dm.dm_req       <= 1'b0;
      dm.dm_we        <= 1'b0;
      dm.dm_addr      <= 32'd0;
      dm.dm_wdata     <= 32'd0;
      wb_ALURes       <= 32'd0;
      wb_mem_data     <= 32'd0;
      wb_ext          <= 32'd0;
      wb_reg_write_no <= 5'd0;
      wb_RegWrite     <= 1'b0;
      wb_DatatoReg    <= 2'd0;
      bus_err         <= 1'b0;
      align_err       <= 1'b0;
    end else begin
      bus_err   <= 1'b0;
      align_err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (mem_op_s && misalign_s) begin
            wb_ALURes       <= ALURes;
            wb_ext          <= ext;
            wb_reg_write_no <= reg_write_no;
            wb_DatatoReg    <= DatatoReg;
            wb_RegWrite     <= 1'b0;
            wb_mem_data     <= 32'd0;
            align_err       <= 1'b1;
          end else if (mem_op_s) begin
            state_r     <= ACCESS;
            cnt_r       <= 8'd0;
            dm.dm_req   <= 1'b1;
            dm.dm_we    <= MemWrite;
            dm.dm_addr  <= {ALURes[31:2], 2'b00};
            dm.dm_wdata <= grf_out_B;
            wb_RegWrite <= 1'b0;
          end else begin
            wb_ALURes       <= ALURes;
            wb_ext          <= ext;
            wb_reg_write_no <= reg_write_no;
            wb_DatatoReg    <= DatatoReg;
            wb_RegWrite     <= RegWrite;
            wb_mem_data     <= 32'd0;
          end
        end
        ACCESS: begin
          if (dm.dm_ack) begin
            wb_ALURes       <= ALURes;
            wb_ext          <= ext;
            wb_reg_write_no <= reg_write_no;
            wb_DatatoReg    <= DatatoReg;
            wb_RegWrite     <= RegWrite;
            // the latched write enable tells a store (MemWrite wins) from a load
            wb_mem_data     <= dm.dm_we ? 32'd0 : dm.dm_rdata;
            state_r         <= IDLE;
            dm.dm_req       <= 1'b0;
            dm.dm_we        <= 1'b0;
          end else if (cnt_r == CNT_LAST) begin
            wb_ALURes       <= ALURes;
            wb_ext          <= ext;
            wb_reg_write_no <= reg_write_no;
            wb_DatatoReg    <= DatatoReg;
            wb_RegWrite     <= 1'b0;
            wb_mem_data     <= 32'd0;
            bus_err         <= 1'b1;
            state_r         <= IDLE;
            dm.dm_req       <= 1'b0;
            dm.dm_we        <= 1'b0;
          end else begin
            cnt_r       <= cnt_r + 8'd1;
            wb_RegWrite <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= 8'd0;
          dm.dm_req <= 1'b0;
          dm.dm_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage: per-instruction transaction model
// (latency from the chosen ack delay) with a negedge compare process.
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic [31:0] ALURes, grf_out_B, ext;
  logic [4:0]  reg_write_no;
  logic        MemRead, MemWrite, RegWrite;
  logic [1:0]  DatatoReg;
  logic        stall;
  logic [31:0] wb_ALURes, wb_mem_data, wb_ext;
  logic [4:0]  wb_reg_write_no;
  logic        wb_RegWrite;
  logic [1:0]  wb_DatatoReg;
  logic        bus_err, align_err;

  mem_access_stage_if dm_bus ();

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ALURes(ALURes), .grf_out_B(grf_out_B), .ext(ext), .reg_write_no(reg_write_no),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .DatatoReg(DatatoReg),
    .stall(stall), .dm(dm_bus),
    .wb_ALURes(wb_ALURes), .wb_mem_data(wb_mem_data), .wb_ext(wb_ext),
    .wb_reg_write_no(wb_reg_write_no), .wb_RegWrite(wb_RegWrite), .wb_DatatoReg(wb_DatatoReg),
    .bus_err(bus_err), .align_err(align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int stall_cnt, req_cnt, we_cnt;
  logic chk_en;
  logic [31:0] last_req_addr;

  // model expectations
  logic        exp_stall, exp_req, exp_we;
  logic [31:0] exp_addr, exp_wdata;
  logic [31:0] exp_wb_alu, exp_wb_mem, exp_wb_ext;
  logic [4:0]  exp_wb_rd;
  logic        exp_wb_rw;
  logic [1:0]  exp_wb_d2r;
  logic        exp_bus_err, exp_align_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_zero();
    exp_wb_alu = 32'd0; exp_wb_mem = 32'd0; exp_wb_ext = 32'd0;
    exp_wb_rd = 5'd0; exp_wb_rw = 1'b0; exp_wb_d2r = 2'd0;
    exp_bus_err = 1'b0; exp_align_err = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("dm_req", 32'(dm_bus.dm_req), 32'(exp_req));
      if (exp_req) begin
        chk("dm_addr", dm_bus.dm_addr, exp_addr);
        chk("dm_we", 32'(dm_bus.dm_we), 32'(exp_we));
        chk("dm_wdata", dm_bus.dm_wdata, exp_wdata);
        last_req_addr = dm_bus.dm_addr;
      end
      chk("wb_ALURes", wb_ALURes, exp_wb_alu);
      chk("wb_mem_data", wb_mem_data, exp_wb_mem);
      chk("wb_ext", wb_ext, exp_wb_ext);
      chk("wb_reg_write_no", 32'(wb_reg_write_no), 32'(exp_wb_rd));
      chk("wb_RegWrite", 32'(wb_RegWrite), 32'(exp_wb_rw));
      chk("wb_DatatoReg", 32'(wb_DatatoReg), 32'(exp_wb_d2r));
      chk("bus_err", 32'(bus_err), 32'(exp_bus_err));
      chk("align_err", 32'(align_err), 32'(exp_align_err));
      stall_cnt += int'(stall);
      req_cnt   += int'(dm_bus.dm_req);
      we_cnt    += int'(dm_bus.dm_req & dm_bus.dm_we);
    end
  end

  // Presents one instruction for its whole stay in the stage; dly = ACCESS cycle index of
  // the ack (dly >= TO means no ack). cut >= 0 returns early at the start of that cycle.
  task automatic run_instr(input logic [31:0] alu, input logic [31:0] b, input logic [31:0] ex,
                           input logic [4:0] rd, input logic mr, input logic mw, input logic rw,
                           input logic [1:0] d2r, input int dly, input logic [31:0] rdat,
                           input int cut);
    logic mop, mis, acc, abort, ld;
    int n;
    mop = mr | mw;
`ifdef MEM_ALIGN_CHECK_EN
    mis = mop && (alu[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    acc   = mop && !mis;
    abort = acc && (dly >= TO);
    ld    = mr && !mw;
    if (!acc) n = 1;
    else if (abort) n = TO + 1;
    else n = dly + 2;
    ALURes = alu; grf_out_B = b; ext = ex; reg_write_no = rd;
    MemRead = mr; MemWrite = mw; RegWrite = rw; DatatoReg = d2r;
    stall_cnt = 0; req_cnt = 0; we_cnt = 0;
    for (int c = 0; c < n; c++) begin
      if (c == cut) return;
      if (acc && c >= 1) dm_bus.dm_ack = (c - 1 == dly);
      else dm_bus.dm_ack = 1'($urandom_range(0, 1));
      dm_bus.dm_rdata = (acc && (c - 1 == dly)) ? rdat : $urandom;
      exp_stall = acc && (c < n - 1);
      exp_req   = acc && (c >= 1);
      exp_addr  = {alu[31:2], 2'b00};
      exp_we    = mw;
      exp_wdata = b;
      chk_en = 1'b1;
      @(posedge clk); #1;
      if (c == n - 1) begin
        exp_wb_alu = alu; exp_wb_ext = ex; exp_wb_rd = rd; exp_wb_d2r = d2r;
        exp_wb_rw  = (abort || mis) ? 1'b0 : rw;
        exp_wb_mem = (ld && acc && !abort) ? rdat : 32'd0;
        exp_bus_err = abort;
        exp_align_err = mis;
      end else begin
        exp_wb_rw = 1'b0;
        exp_bus_err = 1'b0;
        exp_align_err = 1'b0;
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    int k, r, d;
    chk_en = 1'b0;
    rst = 1'b0;
    ALURes = 32'd0; grf_out_B = 32'd0; ext = 32'd0; reg_write_no = 5'd0;
    MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0; DatatoReg = 2'd0;
    dm_bus.dm_ack = 1'b0; dm_bus.dm_rdata = 32'd0;
    last_req_addr = 32'd0;
    model_zero();
    #1;
    chk("rst_dm_req", 32'(dm_bus.dm_req), 32'd0);
    chk("rst_wb_ALURes", wb_ALURes, 32'd0);
    chk("rst_wb_RegWrite", 32'(wb_RegWrite), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // ALU instruction
    run_instr(32'h1234, 32'h0, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 2'd0, 0, 32'h0, -1);
    chk("alu_wb_ALURes", wb_ALURes, 32'h1234);
    chk("alu_wb_rd", 32'(wb_reg_write_no), 32'd5);
    chk("alu_wb_RegWrite", 32'(wb_RegWrite), 32'd1);
    chk("alu_stall_cycles", 32'(stall_cnt), 32'd0);
    chk("alu_req_cycles", 32'(req_cnt), 32'd0);

    // load, ack on 3rd request cycle
    run_instr(32'h100, 32'h0, 32'h77, 5'd7, 1'b1, 1'b0, 1'b1, 2'd1, 2, 32'hDEADBEEF, -1);
    chk("ld_stall_cycles", 32'(stall_cnt), 32'd3);
    chk("ld_req_cycles", 32'(req_cnt), 32'd3);
    chk("ld_wb_mem_data", wb_mem_data, 32'hDEADBEEF);
    chk("ld_wb_RegWrite", 32'(wb_RegWrite), 32'd1);
    chk("ld_addr", last_req_addr, 32'h100);

    // store, immediate ack
    run_instr(32'h200, 32'hA5A5A5A5, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 2'd0, 0, 32'h0, -1);
    chk("st_stall_cycles", 32'(stall_cnt), 32'd1);
    chk("st_we_cycles", 32'(we_cnt), 32'd1);
    chk("st_bus_err", 32'(bus_err), 32'd0);
    chk("st_wb_mem_data", wb_mem_data, 32'd0);

    // timeout
    run_instr(32'h300, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 2'd1, TO + 1, 32'h0, -1);
    chk("to_req_cycles", 32'(req_cnt), 32'd4);
    chk("to_bus_err", 32'(bus_err), 32'd1);
    chk("to_wb_mem_data", wb_mem_data, 32'd0);
    chk("to_wb_RegWrite", 32'(wb_RegWrite), 32'd0);
    run_instr(32'h55, 32'h0, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1, 2'd0, 0, 32'h0, -1);
    chk("to_next_stall", 32'(stall_cnt), 32'd0);
    chk("to_next_wb_ALURes", wb_ALURes, 32'h55);

    // reset in the 2nd ACCESS cycle of a load
    run_instr(32'h400, 32'h0, 32'h1, 5'd4, 1'b1, 1'b0, 1'b1, 2'd1, 100, 32'h0, 2);
    chk_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_dm_req", 32'(dm_bus.dm_req), 32'd0);
    chk("mid_rst_wb_ALURes", wb_ALURes, 32'd0);
    chk("mid_rst_wb_ext", wb_ext, 32'd0);
    chk("mid_rst_wb_rd", 32'(wb_reg_write_no), 32'd0);
    chk("mid_rst_wb_d2r", 32'(wb_DatatoReg), 32'd0);
    model_zero();
    @(posedge clk); #1 rst = 1'b1;
    run_instr(32'h9999, 32'h0, 32'h2, 5'd11, 1'b0, 1'b0, 1'b1, 2'd2, 0, 32'h0, -1);
    chk("post_rst_stall", 32'(stall_cnt), 32'd0);
    chk("post_rst_wb_ALURes", wb_ALURes, 32'h9999);
    chk("post_rst_wb_RegWrite", 32'(wb_RegWrite), 32'd1);

    // misaligned load
    last_req_addr = 32'd0;
    run_instr(32'h102, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 2'd1, 0, 32'h12345678, -1);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_req_cycles", 32'(req_cnt), 32'd0);
    chk("mis_align_err", 32'(align_err), 32'd1);
    chk("mis_wb_RegWrite", 32'(wb_RegWrite), 32'd0);
`else
    chk("mis_addr", last_req_addr, 32'h100);
    chk("mis_align_err", 32'(align_err), 32'd0);
    chk("mis_wb_mem_data", wb_mem_data, 32'h12345678);
`endif

    // randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 3);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      r = $urandom_range(0, 9);
      if (r < 6) d = r % 3;
      else if (r < 8) d = $urandom_range(0, TO - 1);
      else d = TO + 1;
      run_instr(a, $urandom, $urandom, 5'($urandom), k == 1 || k == 3, k == 2 || k == 3,
                1'($urandom), 2'($urandom), d, $urandom, -1);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
